// File: rtl/exe_status_if.sv
// Execute-stage status/pipeline interface.
// The slave side is the status unit. The master side is the execute stage,
// which drives the EXE instruction and the ID condition field.
interface exe_status_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  // EXE-stage instruction and ALU outputs
  logic [DATA_W-1:0]     alu_result;
  logic [3:0]            alu_status;
  logic                  exe_valid;
  logic                  exe_s;
  logic                  exe_kill;
  logic                  freeze;
  logic [DATA_W-1:0]     exe_val_rm;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r;
  logic                  exe_mem_w;

  // Condition field of the instruction in ID
  logic [3:0]            id_cond;

  // Status outputs
  logic                  alu_c;
  logic [3:0]            status_q;
  logic                  cond_pass;

  // EXE/MEM pipeline register outputs
  logic                  mem_valid;
  logic [DATA_W-1:0]     mem_alu_result;
  logic [DATA_W-1:0]     mem_val_rm;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  mem_mem_r;
  logic                  mem_mem_w;

  modport master (
    output alu_result, alu_status, exe_valid, exe_s, exe_kill, freeze,
           exe_val_rm, exe_dest, exe_wb_en, exe_mem_r, exe_mem_w, id_cond,
    input  alu_c, status_q, cond_pass, mem_valid, mem_alu_result,
           mem_val_rm, mem_dest, mem_wb_en, mem_mem_r, mem_mem_w
  );

  modport slave (
    input  alu_result, alu_status, exe_valid, exe_s, exe_kill, freeze,
           exe_val_rm, exe_dest, exe_wb_en, exe_mem_r, exe_mem_w, id_cond,
    output alu_c, status_q, cond_pass, mem_valid, mem_alu_result,
           mem_val_rm, mem_dest, mem_wb_en, mem_mem_r, mem_mem_w
  );
endinterface

// File: rtl/exe_status_unit.sv
// Execute-stage status unit.
// It holds the architectural NZCV-style status register and feeds the ALU
// carry-in from it. It registers the EXE result and control into EXE/MEM.
// It also evaluates the ID condition code against the flags, with a bypass
// of the flags that the current EXE instruction is about to write.
// Flag order is [3]=Z, [2]=C, [1]=N, [0]=V.
module exe_status_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  exe_status_if.slave  bus
);

  logic [3:0]            status_p1;
  logic                  vld_p1;
  logic                  wb_en_p1;
  logic                  mem_r_p1;
  logic                  mem_w_p1;
  logic [DATA_W-1:0]     result_p1;
  logic [DATA_W-1:0]     val_rm_p1;
  logic [REG_ADDR_W-1:0] dest_p1;

  logic                  commit;
  logic                  exe_flags_live;
  logic [3:0]            flags_eff;

  // Condition-code evaluation against a flag set
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = ~c;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = ~n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = ~v;
      4'h8:    cond_eval = c & ~z;
      4'h9:    cond_eval = ~c | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = ~z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Commit qualification and the flag bypass. Freeze does not gate the
  // bypass: a stalled flag-setting instruction still owns the newest flags.
  always_comb begin
    commit         = bus.exe_valid & ~bus.exe_kill & ~bus.freeze;
    exe_flags_live = bus.exe_valid & bus.exe_s & ~bus.exe_kill;
    flags_eff      = exe_flags_live ? bus.alu_status : status_p1;
  end

  // Status register: updates only when a flag-setting instruction commits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_p1 <= 4'b0000;
    end else if (commit && bus.exe_s) begin
      status_p1 <= bus.alu_status;
    end
  end

  // ---- EXE -> MEM stage boundary ----
  // EXE/MEM register. Priority is freeze (hold all), then kill or bubble
  // (clear control, data holds), then load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      wb_en_p1  <= 1'b0;
      mem_r_p1  <= 1'b0;
      mem_w_p1  <= 1'b0;
      result_p1 <= '0;
      val_rm_p1 <= '0;
      dest_p1   <= '0;
    end else if (bus.freeze) begin
      vld_p1    <= vld_p1;
    end else if (bus.exe_kill || !bus.exe_valid) begin
      vld_p1    <= 1'b0;
      wb_en_p1  <= 1'b0;
      mem_r_p1  <= 1'b0;
      mem_w_p1  <= 1'b0;
    end else begin
      vld_p1    <= 1'b1;
      wb_en_p1  <= bus.exe_wb_en;
      mem_r_p1  <= bus.exe_mem_r;
      mem_w_p1  <= bus.exe_mem_w;
      result_p1 <= bus.alu_result;
      val_rm_p1 <= bus.exe_val_rm;
      dest_p1   <= bus.exe_dest;
    end
  end

  // Output drive. The carry-in comes from the registered flags, not the bypass.
  always_comb begin
    bus.status_q       = status_p1;
    bus.alu_c          = status_p1[2];
    bus.cond_pass      = cond_eval(bus.id_cond, flags_eff);
    bus.mem_valid      = vld_p1;
    bus.mem_wb_en      = wb_en_p1;
    bus.mem_mem_r      = mem_r_p1;
    bus.mem_mem_w      = mem_w_p1;
    bus.mem_alu_result = result_p1;
    bus.mem_val_rm     = val_rm_p1;
    bus.mem_dest       = dest_p1;
  end

endmodule
